// File: rtl/dnn_fc_layer_fix.sv
// dnn_fc_layer_fix: fixed-point fully-connected layer engine.
// The engine shares one read-only memory port for activations, weights and the
// sigmoid LUT. It caches the activation vector, evaluates N_OUT neurons one after
// another with a saturating MAC, and maps each accumulator through the LUT.
// Optional build macro DNN_FC_ARGMAX_EN adds class_idx/class_valid argmax outputs.
module dnn_fc_layer_fix #(
  parameter int                           DATA_WIDTH    = 5,
  parameter int                           ADDR_WIDTH    = 16,
  parameter int                           N_IN          = 400,
  parameter int                           N_OUT         = 10,
  parameter int                           FRAC_BITS     = 3,
  parameter int                           ACC_WIDTH     = 16,
  parameter int                           LUT_AW        = 5,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_A   = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_W   = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_LUT = 16'h29be,
  parameter logic signed [DATA_WIDTH-1:0] BIAS_VAL      = 5'b01000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         acc_sat,
  output logic signed [DATA_WIDTH-1:0] out [N_OUT]
`ifdef DNN_FC_ARGMAX_EN
  ,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] class_idx,
  output logic                         class_valid
`endif
);

  localparam int KW  = $clog2(N_IN + 2);
  localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AIW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int SW  = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  localparam logic [KW-1:0]         K_LAST_A = KW'(N_IN);
  localparam logic [KW-1:0]         K_LAST_M = KW'(N_IN + 1);
  localparam logic [JW-1:0]         J_LAST   = JW'(N_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_A    = ADDR_WIDTH'(N_IN + 1);

  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = ~SUM_MAX;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic signed [ACC_WIDTH-1:0] IDX_MAX  = ACC_WIDTH'((1 << (LUT_AW-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] IDX_MIN  = ACC_WIDTH'(-(1 << (LUT_AW-1)));
  localparam logic signed [ACC_WIDTH-1:0] IDX_HALF = ACC_WIDTH'(1 << (LUT_AW-1));

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_MAC, S_LUT_RD, S_LUT_WR, S_DONE
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [KW-1:0]                  r_k;
  logic [JW-1:0]                  r_j;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic                           r_sat;
  logic [ADDR_WIDTH-1:0]          r_wbase;
  logic [ADDR_WIDTH-1:0]          r_addr_q;
  logic signed [DATA_WIDTH-1:0]   r_abuf [N_IN];
  logic signed [DATA_WIDTH-1:0]   r_out  [N_OUT];

  logic [AIW-1:0]                 w_aidx;
  logic signed [DATA_WIDTH-1:0]   w_op;
  logic signed [PW-1:0]           w_prod;
  logic [ACC_WIDTH:0]             w_sum;
  logic [ADDR_WIDTH-1:0]          w_addr;
  logic                           w_soft_rst;

  // Accumulate with clamping; MSB of the result flags that a clamp occurred.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] acc,
                                                 input logic signed [PW-1:0]        prod);
    logic signed [SW-1:0] sum;
    sum = $signed({{(SW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc})
        + $signed({{(SW-PW){prod[PW-1]}}, prod});
    if (sum > SUM_MAX)      return {1'b1, ACC_MAX};
    else if (sum < SUM_MIN) return {1'b1, ACC_MIN};
    else                    return {1'b0, ACC_WIDTH'(sum)};
  endfunction

  // Integer part of the accumulator, clamped to the LUT range and re-biased to 0..2^LUT_AW-1.
  function automatic logic [LUT_AW-1:0] lut_off(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] idx;
    idx = acc >>> FRAC_BITS;
    if (idx > IDX_MAX)      idx = IDX_MAX;
    else if (idx < IDX_MIN) idx = IDX_MIN;
    idx = idx + IDX_HALF;
    return LUT_AW'(idx);
  endfunction

  assign w_soft_rst = rst || clear;
  assign w_aidx     = AIW'(r_k - KW'(1));
  assign w_op       = (r_k == K_LAST_M) ? BIAS_VAL : r_abuf[w_aidx];
  assign w_prod     = $signed({{DATA_WIDTH{mem_data[DATA_WIDTH-1]}}, mem_data})
                    * $signed({{DATA_WIDTH{w_op[DATA_WIDTH-1]}}, w_op});
  assign w_sum      = sat_add(r_acc, w_prod);
  assign out        = r_out;
  assign acc_sat    = r_sat;

  // State register; rst and clear both return the engine to IDLE.
  always_ff @(posedge clk) begin
    if (w_soft_rst) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, memory address and status decode; address holds when no read is issued.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = r_addr_q;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (r_k != K_LAST_A) w_addr = ADDR_BASE_A + ADDR_WIDTH'(r_k);
        else                 w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (r_k != K_LAST_M) w_addr = r_wbase + ADDR_WIDTH'(r_k);
        else                 w_state_nxt = S_LUT_RD;
      end
      S_LUT_RD: begin
        w_addr      = ADDR_BASE_LUT + ADDR_WIDTH'(lut_off(r_acc));
        w_state_nxt = S_LUT_WR;
      end
      S_LUT_WR: begin
        w_state_nxt = (r_j == J_LAST) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_state_nxt = S_LOAD_A;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_addr = w_addr;

  // Counters, activation cache, accumulator and neuron outputs.
  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_k      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_wbase  <= ADDR_BASE_W;
      r_addr_q <= '0;
      for (int i = 0; i < N_IN; i++)  r_abuf[i] <= '0;
      for (int i = 0; i < N_OUT; i++) r_out[i]  <= '0;
    end else begin
      r_addr_q <= w_addr;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_k     <= '0;
            r_j     <= '0;
            r_sat   <= 1'b0;
            r_wbase <= ADDR_BASE_W;
          end
        end
        S_LOAD_A: begin
          // Read data lags the address by one cycle, so cycle k captures word k-1.
          if (r_k != '0) r_abuf[w_aidx] <= mem_data;
          if (r_k == K_LAST_A) begin
            r_k   <= '0;
            r_acc <= '0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_MAC: begin
          if (r_k != '0) begin
            r_acc <= ACC_WIDTH'(w_sum);
            if (w_sum[ACC_WIDTH]) r_sat <= 1'b1;
          end
          if (r_k == K_LAST_M) r_k <= '0;
          else                 r_k <= r_k + KW'(1);
        end
        S_LUT_WR: begin
          r_out[r_j] <= mem_data;
          if (r_j != J_LAST) begin
            r_j     <= r_j + JW'(1);
            r_wbase <= r_wbase + ROW_A;
            r_acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DNN_FC_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [JW-1:0]                r_cls;

  // Running argmax over LUT results; only a strictly larger value moves the index.
  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_max <= '0;
      r_cls <= '0;
    end else if (r_state == S_LUT_WR) begin
      if ((r_j == '0) || (mem_data > r_max)) begin
        r_max <= mem_data;
        r_cls <= r_j;
      end
    end
  end

  assign class_idx   = r_cls;
  assign class_valid = done;
`endif

endmodule

// File: tb/tb_dnn_fc_layer_fix.sv
// Testbench for dnn_fc_layer_fix: two instances (16-bit and 8-bit accumulators)
// share one memory image and are checked against a behavioural layer model.
module tb_dnn_fc_layer_fix;

  localparam int DW  = 5;
  localparam int AW  = 8;
  localparam int NI  = 2;
  localparam int NO  = 2;
  localparam int FB  = 3;
  localparam int BA  = 0;
  localparam int BW  = 16;
  localparam int BL  = 32;
  localparam int LAT = 1 + (NI + 1) + NO * (NI + 4);

  logic clk = 1'b0;
  logic rst, start, clear;
  logic signed [DW-1:0] mem [256];
  logic signed [DW-1:0] md_a, md_b;
  logic [AW-1:0]        ma_a, ma_b;
  logic                 busy_a, done_a, sat_a, busy_b, done_b, sat_b;
  logic signed [DW-1:0] out_a [NO];
  logic signed [DW-1:0] out_b [NO];
`ifdef DNN_FC_ARGMAX_EN
  logic cls_a, cv_a, cls_b, cv_b;
`endif

  int n_chk, n_fail;
  int trace[$];

  always #5 clk = ~clk;

  // Synchronous read-only memory: data is valid the cycle after the address.
  always @(posedge clk) begin
    md_a <= mem[ma_a];
    md_b <= mem[ma_b];
  end

  dnn_fc_layer_fix #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(FB),
    .ACC_WIDTH(16), .LUT_AW(5), .ADDR_BASE_A(8'h00), .ADDR_BASE_W(8'h10),
    .ADDR_BASE_LUT(8'h20), .BIAS_VAL(5'sd8)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .mem_data(md_a),
    .mem_addr(ma_a), .busy(busy_a), .done(done_a), .acc_sat(sat_a), .out(out_a)
`ifdef DNN_FC_ARGMAX_EN
    , .class_idx(cls_a), .class_valid(cv_a)
`endif
  );

  dnn_fc_layer_fix #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(FB),
    .ACC_WIDTH(8), .LUT_AW(5), .ADDR_BASE_A(8'h00), .ADDR_BASE_W(8'h10),
    .ADDR_BASE_LUT(8'h20), .BIAS_VAL(5'sd8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .mem_data(md_b),
    .mem_addr(ma_b), .busy(busy_b), .done(done_b), .acc_sat(sat_b), .out(out_b)
`ifdef DNN_FC_ARGMAX_EN
    , .class_idx(cls_b), .class_valid(cv_b)
`endif
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input int a0, input int a1);
    mem[BA]     = DW'(a0);
    mem[BA + 1] = DW'(a1);
  endtask

  task automatic set_w(input int j, input int w0, input int w1, input int w2);
    mem[BW + j*(NI+1)]     = DW'(w0);
    mem[BW + j*(NI+1) + 1] = DW'(w1);
    mem[BW + j*(NI+1) + 2] = DW'(w2);
  endtask

  // Layer reference: dot product plus bias with per-step clamping, then LUT lookup.
  task automatic model(input int accw, output int o[NO], output int la[NO], output int sat);
    int lo, hi, acc, s, op, idx;
    lo  = -(1 << (accw - 1));
    hi  = (1 << (accw - 1)) - 1;
    sat = 0;
    for (int j = 0; j < NO; j++) begin
      acc = 0;
      for (int k = 0; k <= NI; k++) begin
        op = (k < NI) ? int'(mem[BA + k]) : (1 << FB);
        s  = acc + int'(mem[BW + j*(NI+1) + k]) * op;
        if (s > hi)      begin s = hi; sat = 1; end
        else if (s < lo) begin s = lo; sat = 1; end
        acc = s;
      end
      idx = acc >>> FB;
      if (idx > 15)       idx = 15;
      else if (idx < -16) idx = -16;
      la[j] = BL + idx + 16;
      o[j]  = int'(mem[la[j]]);
    end
  endtask

  function automatic int amax(input int o[NO]);
    int c = 0;
    for (int j = 1; j < NO; j++) if (o[j] > o[c]) c = j;
    return c;
  endfunction

  // Start a run; optionally pulse start again mid-run (must be ignored).
  task automatic run(input int glitch, output int lat, output logic d1);
    int last = -1;
    trace.delete();
    start = 1'b1;
    lat   = 0;
    d1    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == 1) d1 = done_a;
      if (busy_a && int'(ma_a) != last) begin
        trace.push_back(int'(ma_a));
        last = int'(ma_a);
      end
      if (done_a) break;
      if (glitch != 0 && lat == glitch) start = 1'b1;
    end
  endtask

  task automatic verify(input string tag, input int lat, input logic d1);
    int oa[NO], ob[NO], la[NO], lb[NO], sa, sb;
    int exp_tr[$];
    model(16, oa, la, sa);
    model(8,  ob, lb, sb);
    chk({tag, "_done_drop"}, d1, 0);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_done_b"}, done_b, 1);
    chk({tag, "_busy_a"}, busy_a, 0);
    for (int j = 0; j < NO; j++) begin
      chk($sformatf("%s_out_a%0d", tag, j), out_a[j], oa[j]);
      chk($sformatf("%s_out_b%0d", tag, j), out_b[j], ob[j]);
    end
    chk({tag, "_sat_a"}, sat_a, sa);
    chk({tag, "_sat_b"}, sat_b, sb);
`ifdef DNN_FC_ARGMAX_EN
    chk({tag, "_cls_a"}, cls_a, amax(oa));
    chk({tag, "_cls_b"}, cls_b, amax(ob));
    chk({tag, "_cv_a"}, cv_a, 1);
    chk({tag, "_cv_b"}, cv_b, 1);
`endif
    for (int k = 0; k < NI; k++) exp_tr.push_back(BA + k);
    for (int j = 0; j < NO; j++) begin
      for (int k = 0; k <= NI; k++) exp_tr.push_back(BW + j*(NI+1) + k);
      exp_tr.push_back(la[j]);
    end
    chk({tag, "_trace_len"}, trace.size(), exp_tr.size());
    if (trace.size() == exp_tr.size())
      for (int i = 0; i < exp_tr.size(); i++)
        chk($sformatf("%s_trace%0d", tag, i), trace[i], exp_tr[i]);
  endtask

  function automatic int rnd();
    return int'($urandom_range(31, 0)) - 16;
  endfunction

  initial begin
    int   lat;
    logic d1;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    clear  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int k = 0; k < 32; k++)  mem[BL + k] = DW'(k - 16);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_addr", ma_a, 0);
    chk("rst_out0", out_a[0], 0);
    chk("rst_out1_b", out_b[1], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy_a, 0);

    // Basic run
    set_a(8, -8); set_w(0, 8, 0, 0); set_w(1, 0, 8, 8);
    run(0, lat, d1); verify("basic", lat, d1);
    chk("basic_out0_const", out_a[0], 8);
    chk("basic_out1_const", out_a[1], 0);
    chk("basic_sat_const", sat_a, 0);

    // Restart directly from DONE
    run(0, lat, d1); verify("restart", lat, d1);
    chk("restart_out0_const", out_a[0], 8);

    // LUT index clamp, both directions
    set_a(15, -16); set_w(0, 15, -16, 15); set_w(1, 1, 2, 3);
    run(0, lat, d1); verify("lut_pos", lat, d1);
    chk("lut_pos_const", out_a[0], 15);
    set_a(15, 15); set_w(0, -16, -16, -16);
    run(0, lat, d1); verify("lut_neg", lat, d1);
    chk("lut_neg_const", out_a[0], -16);

    // Accumulator saturation on the 8-bit instance
    set_a(15, 15); set_w(0, 15, 15, 0); set_w(1, 0, 0, 0);
    run(0, lat, d1); verify("accsat", lat, d1);
    chk("accsat_b_const", sat_b, 1);
    chk("accsat_b_out0", out_b[0], 15);
    chk("accsat_a_const", sat_a, 0);

    // Mid-run clear during neuron 1 MAC; start asserted with clear must lose
    set_a(8, -8); set_w(0, 8, 0, 0); set_w(1, 0, 8, 8);
    run(0, lat, d1); verify("preclear", lat, d1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", busy_a, 1);
    chk("mid_out0", out_a[0], 8);
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    chk("clr_busy", busy_a, 0);
    chk("clr_done", done_a, 0);
    chk("clr_out0", out_a[0], 0);
    chk("clr_out1", out_a[1], 0);
    chk("clr_addr", ma_a, 0);
    chk("clr_sat_b", sat_b, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("clr_stays_idle", busy_a, 0);
    run(0, lat, d1); verify("postclear", lat, d1);
    chk("postclear_out0", out_a[0], 8);

`ifdef DNN_FC_ARGMAX_EN
    set_a(8, 0); set_w(0, 5, 0, 0); set_w(1, 5, 0, 0);
    run(0, lat, d1); verify("amax_tie", lat, d1);
    chk("amax_tie_const", cls_a, 0);
    set_w(0, 3, 0, 0); set_w(1, 7, 0, 0);
    run(0, lat, d1); verify("amax_gt", lat, d1);
    chk("amax_gt_const", cls_a, 1);
`endif

    // Randomised runs, some with a stray start pulse while busy
    for (int t = 0; t < 24; t++) begin
      set_a(rnd(), rnd());
      for (int j = 0; j < NO; j++) set_w(j, rnd(), rnd(), rnd());
      run((t % 2 == 1) ? int'($urandom_range(14, 2)) : 0, lat, d1);
      verify($sformatf("rnd%0d", t), lat, d1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn_fc_layer_fix.md
Name: dnn_fc_layer_fix

Overview:
Parametrised fixed-point fully-connected layer engine. Reads activations, weights and a sigmoid LUT from a single shared read-only memory port. Caches activations internally, computes N_OUT neurons sequentially with a saturating MAC, and maps each result through the LUT. Generalises the fixed 5-bit, 10-output sigmoid engines to arbitrary width, fan-in, fan-out and fraction format, and adds an accumulator saturation flag and optional argmax.

Parameters:
DATA_WIDTH, 5, signed word width of activations, weights, LUT entries and outputs
ADDR_WIDTH, 16, memory address width
N_IN, 400, inputs per neuron (excluding bias)
N_OUT, 10, neurons in layer
FRAC_BITS, 3, fractional bits of the fixed-point format
ACC_WIDTH, 16, signed accumulator width
LUT_AW, 5, log2 of LUT entry count
ADDR_BASE_A, 16'h0000, base address of activation vector
ADDR_BASE_W, 16'h0191, base address of weight matrix
ADDR_BASE_LUT, 16'h29be, base address of sigmoid LUT
BIAS_VAL, 5'b01000, constant multiplying the bias weight (1.0 in Q.FRAC_BITS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin layer computation (sampled in IDLE only)
clear  in  1  synchronous soft abort; same effect as rst
mem_data  in  DATA_WIDTH  signed read data; valid the cycle after mem_addr
mem_addr  out  ADDR_WIDTH  read address
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
acc_sat  out  1  sticky: some neuron's accumulator saturated this run
out  out  N_OUT x DATA_WIDTH  signed neuron outputs (unpacked array)

Behaviour:
- Clocking: one clock, clk. rst and clear are synchronous and active-high. Either one forces IDLE, mem_addr=0, busy=0, done=0, acc_sat=0, all out[]=0, internal buffers and counters cleared. This applies mid-run too, with no partial writes.
- States: IDLE, LOAD_A, MAC, LUT_RD, LUT_WR, DONE.
- IDLE: start=1 -> LOAD_A; neuron index j=0.
- LOAD_A: N_IN+1 cycles, k=0..N_IN.
  - For k<N_IN: mem_addr=ADDR_BASE_A+k.
  - For k>=1: a_buf[k-1]<=mem_data.
  - Then -> MAC.
- MAC: N_IN+2 cycles, k=0..N_IN+1. Accumulator is zeroed on entry.
  - For k<=N_IN: mem_addr=ADDR_BASE_W+j*(N_IN+1)+k. Word N_IN of each row is the bias weight.
  - For k>=1: acc<=sat(acc + mem_data*op). op=a_buf[k-1] if k-1<N_IN, else BIAS_VAL.
  - Product is 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Sum is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets acc_sat.
- LUT_RD: 1 cycle.
  - idx = acc>>>FRAC_BITS (arithmetic), clamped to [-2^(LUT_AW-1), 2^(LUT_AW-1)-1].
  - mem_addr=ADDR_BASE_LUT+idx+2^(LUT_AW-1).
- LUT_WR: 1 cycle.
  - out[j]<=mem_data.
  - If j==N_OUT-1 -> DONE, else j++ and -> MAC.
- DONE: done=1; out[] and acc_sat are held.
  - start=1 -> LOAD_A. This restarts the run, clears acc_sat, and holds out[] until overwritten.
  - Otherwise DONE persists.
- Latency: done rises 1+(N_IN+1)+N_OUT*(N_IN+4) cycles after the edge that samples start.
- Unused mem_addr cycles (IDLE, DONE, last cycle of LOAD_A and MAC): mem_addr holds its last value.
- out[j] only changes in LUT_WR for that j, or on reset/clear.
- start outside IDLE/DONE is ignored. If clear and start are asserted together, clear wins.

Optional Feature:
DNN_FC_ARGMAX_EN.
- Defined: adds ports class_idx out $clog2(N_OUT) and class_valid out 1.
  - A running max updates in each LUT_WR. A strictly greater value replaces the max; ties keep the lower index.
  - class_valid=1 together with done; it resets to 0 on rst/clear/start.
  - class_idx resets to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
All tests use N_IN=2, N_OUT=2, DATA_WIDTH=5, FRAC_BITS=3, LUT_AW=5, bases A=0, W=16, LUT=32, and LUT[k]=k-16.
- Basic: a=[8,-8], W row0=[8,0,0], row1=[0,8,8], start pulse -> out[0]=8, out[1]=0. done rises exactly 16 cycles after the start edge; acc_sat=0.
- LUT clamp: a=[15,-16], row0=[15,-16,15] (acc=601, idx clamped to 15) -> out[0]=15. Negative mirror a=[15,15], row0=[-16,-16,-16] -> out[0]=-16.
- Accumulator saturation: ACC_WIDTH=8, a=[15,15], row0=[15,15,0] -> acc clamps at 127, acc_sat=1, out[0]=15.
- Mid-run clear: assert clear during MAC of neuron 1 -> next cycle IDLE, busy=0, out[]=0. A subsequent start gives the same results as the Basic test.
- Restart from DONE: start while done=1 -> done drops next cycle and a new run completes in 16 cycles. Address trace matches 0,1,16,17,18,<lut>,19,20,21,<lut>.
- ARGMAX (DNN_FC_ARGMAX_EN): outputs [5,5] -> class_idx=0; outputs [3,7] -> class_idx=1. class_valid is asserted together with done.
